// File: rtl/c7bexc_ctl.sv
// c7b exception/interrupt commit controller: arbitrates faults and interrupts in e,
// registers one commit event into w, then holds a flush window. Macro: C7B_EXT_INTR_SYNC_EN.
module c7bexc_ctl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_e,
  input  logic [31:0] pc_e,
  input  logic        adef_e,
  input  logic        ale_e,
  input  logic        ine_e,
  input  logic        sys_e,
  input  logic        brk_e,
  input  logic        ertn_e,
  input  logic [31:0] badv_e,
  input  logic        csr_ecl_crmd_ie,
  input  logic        csr_ecl_timer_intr,
  input  logic        ext_intr,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        exu_ifu_except,
  output logic [5:0]  ecl_csr_exccode_w,
  output logic [31:0] ecl_csr_badv_w,
  output logic [31:0] ifu_exu_pc_w,
  output logic        ecl_csr_ertn_w,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_w,
  output logic        ext_intr_sync
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_except, r_ertn, r_redir, r_flush;
  logic [5:0]  r_code;
  logic [31:0] r_badv, r_pc;
  logic        r_sync;

`ifdef C7B_EXT_INTR_SYNC_EN
  logic r_meta;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= ext_intr;
      r_sync <= r_meta;
    end
  end
`else
  // Only safe when ext_intr is already launched from clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 1'b0;
    else     r_sync <= ext_intr;
  end
`endif

  logic       w_intr, w_fault, w_exc, w_ertn, w_badv_ld;
  logic [5:0] w_code;

  assign w_intr    = csr_ecl_crmd_ie & (csr_ecl_timer_intr | r_sync);
  assign w_fault   = adef_e | ale_e | ine_e | sys_e | brk_e;
  assign w_exc     = valid_e & (w_intr | w_fault);
  assign w_ertn    = valid_e & ertn_e & ~(w_intr | w_fault);
  assign w_badv_ld = ~w_intr & (adef_e | ale_e);

  always_comb begin
    w_code = 6'h0D;
    if      (w_intr) w_code = 6'h00;
    else if (adef_e) w_code = 6'h08;
    else if (ale_e)  w_code = 6'h09;
    else if (sys_e)  w_code = 6'h0B;
    else if (brk_e)  w_code = 6'h0C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_except <= 1'b0;
      r_ertn   <= 1'b0;
      r_redir  <= 1'b0;
      r_flush  <= 1'b0;
      r_code   <= 6'd0;
      r_badv   <= 32'd0;
      r_pc     <= 32'd0;
    end else begin
      r_except <= 1'b0;
      r_ertn   <= 1'b0;
      r_redir  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_exc | w_ertn) begin
            r_state  <= S_FLUSH;
            r_cnt    <= 4'(FLUSH_CYCLES - 1);
            r_flush  <= 1'b1;
            r_except <= w_exc;
            r_ertn   <= w_ertn;
            r_redir  <= 1'b1;
            r_pc     <= pc_e;
            if (w_exc) r_code <= w_code;
            if (w_exc & w_badv_ld) r_badv <= badv_e;
          end
        end
        S_FLUSH: begin
          // e-stage inputs are ignored here; level interrupts simply wait.
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign exu_ifu_except    = r_except;
  assign ecl_csr_ertn_w    = r_ertn;
  assign redirect_valid    = r_redir;
  assign flush_w           = r_flush;
  assign ecl_csr_exccode_w = r_code;
  assign ecl_csr_badv_w    = r_badv;
  assign ifu_exu_pc_w      = r_pc;
  assign ext_intr_sync     = r_sync;
  // Targets come from the CSRs live in the w cycle, not captured in e.
  assign redirect_pc = r_except ? csr_eentry : (r_ertn ? csr_era : 32'd0);

endmodule

// File: tb/tb_c7bexc_ctl.sv
// Randomized + directed bench for c7bexc_ctl against a cycle-level behavioural model.
module tb_c7bexc_ctl;
  localparam int FC = 2;
`ifdef C7B_EXT_INTR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 0, rst = 1;
  logic valid_e = 0, adef_e = 0, ale_e = 0, ine_e = 0, sys_e = 0, brk_e = 0, ertn_e = 0;
  logic [31:0] pc_e = 0, badv_e = 0, csr_eentry = 32'h1C008000, csr_era = 0;
  logic ie = 0, timer = 0, ext_intr = 0;
  logic except, ertn_w, rvalid, flush, sync;
  logic [5:0] code;
  logic [31:0] badv_w, pc_w, rpc;

  c7bexc_ctl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .pc_e(pc_e), .adef_e(adef_e), .ale_e(ale_e),
    .ine_e(ine_e), .sys_e(sys_e), .brk_e(brk_e), .ertn_e(ertn_e), .badv_e(badv_e),
    .csr_ecl_crmd_ie(ie), .csr_ecl_timer_intr(timer), .ext_intr(ext_intr),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .exu_ifu_except(except),
    .ecl_csr_exccode_w(code), .ecl_csr_badv_w(badv_w), .ifu_exu_pc_w(pc_w),
    .ecl_csr_ertn_w(ertn_w), .redirect_valid(rvalid), .redirect_pc(rpc),
    .flush_w(flush), .ext_intr_sync(sync));

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0;

  // behavioural model state
  bit          m_exc, m_ertn, m_sync;
  logic [5:0]  m_code;
  logic [31:0] m_badv, m_pc;
  int          flush_left;
  bit          hist[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exc = 0; m_ertn = 0; m_sync = 0; m_code = 0; m_badv = 0; m_pc = 0;
    flush_left = 0; hist.delete();
  endtask

  task automatic model_edge();
    bit intr, faults, accept;
    if (rst) begin model_reset(); return; end
    intr   = ie && (timer || m_sync);
    faults = adef_e || ale_e || ine_e || sys_e || brk_e;
    accept = (flush_left == 0) && valid_e && (intr || faults || ertn_e);
    m_exc = 0; m_ertn = 0;
    if (flush_left > 0) flush_left--;
    if (accept) begin
      flush_left = FC;
      m_pc = pc_e;
      if (intr || faults) begin
        m_exc = 1;
        m_code = intr ? 6'h00 : adef_e ? 6'h08 : ale_e ? 6'h09 :
                 sys_e ? 6'h0B : brk_e ? 6'h0C : 6'h0D;
        if (!intr && (adef_e || ale_e)) m_badv = badv_e;
      end else m_ertn = 1;
    end
    hist.push_back(ext_intr);
    if (hist.size() > 4) void'(hist.pop_front());
    m_sync = (hist.size() >= LAT) ? hist[hist.size()-LAT] : 1'b0;
  endtask

  task automatic compare();
    chk("except", except, m_exc);
    chk("ertn", ertn_w, m_ertn);
    chk("redirect_valid", rvalid, m_exc | m_ertn);
    chk("flush", flush, flush_left > 0);
    chk("sync", sync, m_sync);
    chk("exccode", code, m_code);
    chk("badv", badv_w, m_badv);
    chk("pc_w", pc_w, m_pc);
    chk("redirect_pc", rpc, m_exc ? csr_eentry : (m_ertn ? csr_era : 32'd0));
  endtask

  // One clock: update model at the edge, change CSR targets inside the w cycle, then check.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    csr_eentry = $urandom;
    csr_era    = $urandom;
    #1;
    compare();
  endtask

  task automatic clr();
    valid_e = 0; adef_e = 0; ale_e = 0; ine_e = 0; sys_e = 0; brk_e = 0; ertn_e = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk); #1;
    compare();
    chk("rst_except", except, 0);
    chk("rst_pc", pc_w, 0);
    @(negedge clk); rst = 0;
    cyc();

    // misaligned access
    valid_e = 1; ale_e = 1; badv_e = 32'h1003; pc_e = 32'h1C000100;
    cyc();
    chk("ale_except", except, 1);
    chk("ale_code", code, 6'h09);
    chk("ale_badv", badv_w, 32'h1003);
    chk("ale_pc", pc_w, 32'h1C000100);
    chk("ale_rpc", rpc, csr_eentry);
    chk("ale_flush1", flush, 1);
    clr(); cyc();
    chk("ale_flush2", flush, 1);
    cyc();
    chk("ale_flush3", flush, 0);

    // interrupt vs ine
    ie = 1; timer = 1; valid_e = 1; ine_e = 1; pc_e = 32'h1C000104;
    cyc();
    chk("intr_code", code, 6'h00);
    chk("intr_badv_hold", badv_w, 32'h1003);
    clr(); cyc(); cyc();
    ie = 0; valid_e = 1; ine_e = 1;
    cyc();
    chk("ine_code", code, 6'h0D);
    clr(); timer = 0; cyc(); cyc();

    // ertn alone, then ertn + sys
    valid_e = 1; ertn_e = 1;
    cyc();
    csr_era = 32'h1C000200; #1;
    chk("ertn_strobe", ertn_w, 1);
    chk("ertn_noexc", except, 0);
    chk("ertn_rpc", rpc, 32'h1C000200);
    clr(); cyc(); cyc();
    valid_e = 1; ertn_e = 1; sys_e = 1;
    cyc();
    chk("sys_ertn_exc", except, 1);
    chk("sys_ertn_noertn", ertn_w, 0);
    chk("sys_code", code, 6'h0B);

    // brk during flush window is dropped, accepted right after
    clr(); valid_e = 1; brk_e = 1;
    cyc(); chk("brk_ign1", except, 0);
    cyc(); chk("brk_ign2", except, 0);
    cyc(); chk("brk_take", except, 1); chk("brk_code", code, 6'h0C);
    clr(); cyc(); cyc();

    // external interrupt through the synchronizer
    ie = 1; ext_intr = 1;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      chk("ext_sync_lat", sync, (k >= LAT) ? 1 : 0);
    end
    valid_e = 1;
    cyc();
    chk("ext_except", except, 1);
    chk("ext_code", code, 6'h00);
    clr(); ext_intr = 0; ie = 0;
    for (int k = 0; k < LAT + 2; k++) cyc();

    // reset in the first flush cycle
    valid_e = 1; sys_e = 1;
    cyc();
    clr();
    rst = 1; #1;
    model_reset();
    compare();
    chk("midrst_except", except, 0);
    chk("midrst_flush", flush, 0);
    @(negedge clk); rst = 0;
    valid_e = 1; sys_e = 1;
    cyc();
    chk("postrst_except", except, 1);
    chk("postrst_code", code, 6'h0B);
    clr();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      valid_e = ($urandom_range(0, 9) < 7);
      adef_e  = ($urandom_range(0, 19) == 0);
      ale_e   = ($urandom_range(0, 19) == 0);
      ine_e   = ($urandom_range(0, 19) == 0);
      sys_e   = ($urandom_range(0, 19) == 0);
      brk_e   = ($urandom_range(0, 19) == 0);
      ertn_e  = ($urandom_range(0, 14) == 0);
      pc_e    = $urandom;
      badv_e  = $urandom;
      if ($urandom_range(0, 15) == 0) ie = ~ie;
      timer   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) ext_intr = ~ext_intr;
      if (rst) rst = ($urandom_range(0, 2) == 0);
      else     rst = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/c7bexc_ctl.md
# c7bexc_ctl

Exception/interrupt commit controller for the c7b core. It takes per-instruction fault flags from the execute stage, samples pending interrupts, and arbitrates by priority. It registers a single commit event into the writeback stage, driving the CSR block's exception/ertn strobes, exception code, bad-address and PC inputs. It also issues the fetch redirect and a multi-cycle pipeline flush.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush_w` stays high per event (1..15)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- valid_e  in  1  instruction in execute stage is valid
- pc_e  in  32  PC of execute-stage instruction
- adef_e  in  1  fetch address fault
- ale_e  in  1  misaligned load/store
- ine_e  in  1  illegal instruction
- sys_e  in  1  syscall
- brk_e  in  1  break
- ertn_e  in  1  ertn instruction
- badv_e  in  32  faulting address (adef: pc_e; ale: data address)
- csr_ecl_crmd_ie  in  1  global interrupt enable
- csr_ecl_timer_intr  in  1  timer interrupt pending
- ext_intr  in  1  external interrupt line, asynchronous to clk
- csr_eentry  in  32  exception entry address
- csr_era  in  32  exception return address
- exu_ifu_except  out  1  exception/interrupt commit strobe (w stage)
- ecl_csr_exccode_w  out  6  exception code
- ecl_csr_badv_w  out  32  bad virtual address
- ifu_exu_pc_w  out  32  PC of committing instruction
- ecl_csr_ertn_w  out  1  ertn commit strobe
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  redirect target
- flush_w  out  1  kill all younger instructions
- ext_intr_sync  out  1  synchronized ext_intr, forwarded to CSR ESTAT

## Operation
- Interrupt pending: `intr_req = csr_ecl_crmd_ie & (csr_ecl_timer_intr | ext_intr_sync)`.
- Event is accepted only in state IDLE with `valid_e = 1`. Fixed priority, highest first:
  - interrupt, ecode 0x00
  - adef 0x08
  - ale 0x09
  - sys 0x0B
  - brk 0x0C
  - ine 0x0D
  - ertn
- Any exception or interrupt beats ertn. ertn never asserts together with `exu_ifu_except`.
- Exception commit outputs:
  - `exu_ifu_except = 1`
  - `ecl_csr_exccode_w` = winning code
  - `ifu_exu_pc_w` = `pc_e` of that instruction
  - `ecl_csr_badv_w` = `badv_e` for adef/ale; otherwise holds its previous value
  - `redirect_pc = csr_eentry`
- ertn commit outputs: `ecl_csr_ertn_w = 1`, `redirect_pc = csr_era`.
- `csr_eentry` and `csr_era` are sampled in the w cycle, i.e. the cycle the strobe is high.
- FSM:
  - IDLE: on an accepted event go to FLUSH and load `cnt = FLUSH_CYCLES-1`.
  - FLUSH: decrement `cnt`; go to IDLE when `cnt == 0`.
  - While in FLUSH, `valid_e` and all fault flags are ignored. Interrupts stay pending (level) and are taken on the first valid instruction after returning to IDLE.
- `flush_w` is high for the strobe cycle plus the following FLUSH cycles, FLUSH_CYCLES cycles in total.
- Reset, including mid-FLUSH:
  - all outputs 0, `ecl_csr_badv_w`/`ifu_exu_pc_w` = 0, FSM = IDLE, synchronizer flops = 0.
  - A strobe interrupted by reset is dropped, not replayed.

## Timing
- Latency: fault at e in cycle N produces `exu_ifu_except`/`ecl_csr_ertn_w`/`redirect_valid`/`flush_w` in cycle N+1, all registered.
- Strobes are single-cycle pulses. Back-to-back strobes are impossible, since the minimum spacing is FLUSH_CYCLES+1 cycles.
- The CSR block updates ERA/PRMD/CRMD on the N+1 clock edge. An interrupt in N+1 sees the cleared `crmd_ie` from N+2 onward, which the FLUSH window covers for FLUSH_CYCLES ≥ 1.
- `ext_intr` to `ext_intr_sync`: 2 cycles with the synchronizer, 1 cycle without.

## Configuration
- `C7B_EXT_INTR_SYNC_EN` defined: `ext_intr` passes through a 2-flop synchronizer.
- Undefined: a single registered flop. Use this only when `ext_intr` is generated in the clk domain.

## Test plan
- `valid_e=1`, `ale_e=1`, `badv_e=0x1003`, `pc_e=0x1C000100`:
  - next cycle `exu_ifu_except=1`, `ecl_csr_exccode_w=0x09`, `ecl_csr_badv_w=0x1003`, `ifu_exu_pc_w=0x1C000100`, `redirect_pc=csr_eentry`.
  - `flush_w` high exactly 2 cycles.
- `ie=1`, timer pending, `valid_e=1` with `ine_e=1`: interrupt wins with ecode 0x00. With `ie=0` the same stimulus gives ecode 0x0D.
- `ertn_e=1`, `csr_era=0x1C000200`: `ecl_csr_ertn_w=1`, `redirect_pc=0x1C000200`, `exu_ifu_except=0`. With `ertn_e` and `sys_e` together, only `exu_ifu_except` fires, ecode 0x0B.
- `brk_e` on valid instructions in the 2 cycles after an event: ignored. `brk_e` on the 3rd cycle: accepted, ecode 0x0C.
- Pulse `ext_intr` high with `ie=1`:
  - `ext_intr_sync` rises after 2 cycles (macro on).
  - exception strobe with ecode 0x00 on the first following valid instruction.
- Assert `rst` in the first FLUSH cycle: all outputs 0 immediately. A new `sys_e` is accepted in the first cycle after `rst` deasserts.
